// File: rtl/fc_tcdm_arbiter.sv
// Two-initiator round-robin arbiter onto one TCDM target port.
// An in-order ID FIFO remembers who was granted so responses route back to the right initiator.
module fc_tcdm_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  in_req_i,
  input  logic [2*ADDR_WIDTH-1:0]     in_add_i,
  input  logic [1:0]                  in_wen_i,
  input  logic [2*DATA_WIDTH-1:0]     in_wdata_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] in_be_i,
  output logic [1:0]                  in_gnt_o,
  output logic [1:0]                  in_r_valid_o,
  output logic [DATA_WIDTH-1:0]       in_r_rdata_o,
  output logic                        out_req_o,
  output logic [ADDR_WIDTH-1:0]       out_add_o,
  output logic                        out_wen_o,
  output logic [DATA_WIDTH-1:0]       out_wdata_o,
  output logic [DATA_WIDTH/8-1:0]     out_be_o,
  input  logic                        out_gnt_i,
  input  logic                        out_r_valid_i,
  input  logic [DATA_WIDTH-1:0]       out_r_rdata_i,
  output logic                        resp_err_o
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(MAX_OUTSTANDING);

  logic                 rr_ptr;
  logic                 sel;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 pop;
  logic                 head;
  logic                 id_fifo [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign accept = out_req_o & out_gnt_i;
  assign pop    = out_r_valid_i & ~empty;
  assign head   = id_fifo[rd_ptr];

  // A full FIFO blocks new requests even when a pop happens in the same cycle.
  assign out_req_o = (|in_req_i) & ~full;

  always_comb begin
    sel = 1'b0;
    if (in_req_i == 2'b11) begin
      sel = rr_ptr;
    end else if (in_req_i[1]) begin
      sel = 1'b1;
    end
  end

  // Operand isolation: the target bus stays at zero unless a request is presented.
  always_comb begin
    out_add_o   = '0;
    out_wen_o   = 1'b0;
    out_wdata_o = '0;
    out_be_o    = '0;
    if (out_req_o) begin
      out_add_o   = sel ? in_add_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : in_add_i[ADDR_WIDTH-1:0];
      out_wen_o   = in_wen_i[sel];
      out_wdata_o = sel ? in_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : in_wdata_i[DATA_WIDTH-1:0];
      out_be_o    = sel ? in_be_i[2*BE_WIDTH-1:BE_WIDTH] : in_be_i[BE_WIDTH-1:0];
    end
  end

  always_comb begin
    in_gnt_o = 2'b00;
    if (accept) begin
      in_gnt_o[sel] = 1'b1;
    end
  end

  always_comb begin
    in_r_valid_o = 2'b00;
    if (pop) begin
      in_r_valid_o[head] = 1'b1;
    end
  end

  assign in_r_rdata_o = out_r_rdata_i;

  // Priority only rotates on an actual handshake, so a stalled winner keeps its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_err_o <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_fifo[i] <= 1'b0;
      end
    end else begin
      resp_err_o <= out_r_valid_i & empty;
      if (accept) begin
        rr_ptr          <= ~sel;
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_tcdm_arbiter.sv
// Self-checking bench for fc_tcdm_arbiter: directed cycles plus a scoreboard of
// expected response routing pushed on each expected grant.
module tb_fc_tcdm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_req;
  logic [63:0] in_add;
  logic [1:0]  in_wen;
  logic [63:0] in_wdata;
  logic [7:0]  in_be;
  logic [1:0]  in_gnt;
  logic [1:0]  in_r_valid;
  logic [31:0] in_r_rdata;
  logic        out_req;
  logic [31:0] out_add;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_gnt;
  logic        out_r_valid;
  logic [31:0] out_r_rdata;
  logic        resp_err;

  logic [31:0] add0, add1, wdata0, wdata1;
  logic        wen0, wen1;
  logic [3:0]  be0, be1;

  int checks = 0;
  int errors = 0;
  int id_q[$];
  logic err_pending = 1'b0;

  assign in_add   = {add1, add0};
  assign in_wen   = {wen1, wen0};
  assign in_wdata = {wdata1, wdata0};
  assign in_be    = {be1, be0};

  always #5 clk = ~clk;

  fc_tcdm_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_req_i(in_req),
    .in_add_i(in_add),
    .in_wen_i(in_wen),
    .in_wdata_i(in_wdata),
    .in_be_i(in_be),
    .in_gnt_o(in_gnt),
    .in_r_valid_o(in_r_valid),
    .in_r_rdata_o(in_r_rdata),
    .out_req_o(out_req),
    .out_add_o(out_add),
    .out_wen_o(out_wen),
    .out_wdata_o(out_wdata),
    .out_be_o(out_be),
    .out_gnt_i(out_gnt),
    .out_r_valid_i(out_r_valid),
    .out_r_rdata_i(out_r_rdata),
    .resp_err_o(resp_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs 1ns later, scoreboard the response.
  task automatic applyStimulus(input string tag, input logic [1:0] req, input logic gnt,
                               input logic rvalid, input logic [31:0] rdata,
                               input logic [1:0] exp_gnt);
    logic [1:0] exp_v;
    int id;
    @(negedge clk);
    checkOutput({tag, "_resp_err"}, 64'(resp_err), 64'(err_pending));
    in_req      = req;
    out_gnt     = gnt;
    out_r_valid = rvalid;
    out_r_rdata = rdata;
    #1;
    checkOutput({tag, "_gnt"}, 64'(in_gnt), 64'(exp_gnt));
    err_pending = 1'b0;
    if (rvalid) begin
      if (id_q.size() > 0) begin
        id    = id_q.pop_front();
        exp_v = (id == 1) ? 2'b10 : 2'b01;
        checkOutput({tag, "_rdata"}, 64'(in_r_rdata), 64'(rdata));
      end else begin
        exp_v       = 2'b00;
        err_pending = 1'b1;
      end
    end else begin
      exp_v = 2'b00;
    end
    checkOutput({tag, "_rvalid"}, 64'(in_r_valid), 64'(exp_v));
    if (exp_gnt != 2'b00) id_q.push_back(exp_gnt[1] ? 1 : 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    in_req      = 2'b00;
    out_gnt     = 1'b0;
    out_r_valid = 1'b0;
    out_r_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_resp_err", 64'(resp_err), 64'd0);
    checkOutput("rst_out_req", 64'(out_req), 64'd0);
    checkOutput("rst_gnt", 64'(in_gnt), 64'd0);
    checkOutput("rst_rvalid", 64'(in_r_valid), 64'd0);
    checkOutput("rst_out_add", 64'(out_add), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_q.delete();
    err_pending = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_req      = 2'b00;
    out_gnt     = 1'b0;
    out_r_valid = 1'b0;
    out_r_rdata = '0;
    add0 = 32'h0000_1000; wen0 = 1'b1; wdata0 = 32'hAAAA_5555; be0 = 4'h3;
    add1 = 32'h2000_0040; wen1 = 1'b0; wdata1 = 32'h1234_5678; be1 = 4'hF;
    repeat (2) @(posedge clk);
    doReset();

    // Single read from initiator 0 with a two-cycle response.
    applyStimulus("t1_c0", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    checkOutput("t1_add", 64'(out_add), 64'h1000);
    checkOutput("t1_wen", 64'(out_wen), 64'd1);
    applyStimulus("t1_c1", 2'b00, 1'b1, 1'b0, 32'h0, 2'b00);
    applyStimulus("t1_c2", 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b00);

    // Continuous contention alternates starting with initiator 0.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus("t2", 2'b11, 1'b1, k > 0, 32'hA000_0000 + 32'(k),
                    (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    applyStimulus("t2_tail", 2'b00, 1'b1, 1'b1, 32'hA000_0006, 2'b00);

    // FIFO full blocks requests; a pop frees a slot only for the following cycle.
    doReset();
    applyStimulus("t3_c0", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus("t3_c1", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus("t3_c2", 2'b01, 1'b1, 1'b0, 32'h0, 2'b00);
    checkOutput("t3_full_req", 64'(out_req), 64'd0);
    applyStimulus("t3_c3", 2'b01, 1'b1, 1'b1, 32'h3333_0001, 2'b00);
    checkOutput("t3_nobypass_req", 64'(out_req), 64'd0);
    applyStimulus("t3_c4", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus("t3_d0", 2'b00, 1'b0, 1'b1, 32'h3333_0002, 2'b00);
    applyStimulus("t3_d1", 2'b00, 1'b0, 1'b1, 32'h3333_0003, 2'b00);

    // Target stall keeps initiator 1's priority and its address on the bus.
    doReset();
    applyStimulus("t4_c0", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("t4_stall", 2'b11, 1'b0, k == 0, 32'h4444_0000, 2'b00);
      checkOutput("t4_stall_add", 64'(out_add), 64'(add1));
    end
    applyStimulus("t4_go", 2'b11, 1'b1, 1'b0, 32'h0, 2'b10);
    checkOutput("t4_go_add", 64'(out_add), 64'(add1));
    applyStimulus("t4_next", 2'b11, 1'b1, 1'b1, 32'h4444_0001, 2'b01);
    applyStimulus("t4_tail", 2'b00, 1'b0, 1'b1, 32'h4444_0002, 2'b00);

    // Write from initiator 1 alone; idle bus is isolated to zero.
    for (int k = 0; k < 2; k++) begin
      applyStimulus("t5", 2'b10, k == 1, 1'b0, 32'h0, (k == 1) ? 2'b10 : 2'b00);
      checkOutput("t5_add", 64'(out_add), 64'h2000_0040);
      checkOutput("t5_wen", 64'(out_wen), 64'd0);
      checkOutput("t5_wdata", 64'(out_wdata), 64'h1234_5678);
      checkOutput("t5_be", 64'(out_be), 64'hF);
    end
    applyStimulus("t5_resp", 2'b00, 1'b0, 1'b1, 32'h0, 2'b00);
    checkOutput("t5_idle_add", 64'(out_add), 64'd0);
    checkOutput("t5_idle_wdata", 64'(out_wdata), 64'd0);
    checkOutput("t5_idle_be", 64'(out_be), 64'd0);

    // Spurious response, then reset with one outstanding entry.
    applyStimulus("t6_spur", 2'b00, 1'b0, 1'b1, 32'h6666_0000, 2'b00);
    applyStimulus("t6_pulse", 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    applyStimulus("t6_quiet", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    doReset();
    applyStimulus("t6_late", 2'b00, 1'b0, 1'b1, 32'h6666_0001, 2'b00);
    applyStimulus("t6_late_pulse", 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);
    applyStimulus("t6_g0", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus("t6_g1", 2'b01, 1'b1, 1'b0, 32'h0, 2'b01);
    applyStimulus("t6_g2", 2'b01, 1'b1, 1'b0, 32'h0, 2'b00);
    applyStimulus("t6_d0", 2'b00, 1'b0, 1'b1, 32'h6666_0002, 2'b00);
    applyStimulus("t6_d1", 2'b00, 1'b0, 1'b1, 32'h6666_0003, 2'b00);
    applyStimulus("t6_end", 2'b00, 1'b0, 1'b0, 32'h0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_tcdm_arbiter.md
Name: fc_tcdm_arbiter

Overview:
- Shares one TCDM-style target port (req/gnt request phase, r_valid/r_rdata response phase) between two initiators, for example the FC data port and an FC-side debug/DMA master.
- Arbitrates round-robin and tracks up to MAX_OUTSTANDING granted transactions in an in-order ID FIFO.
- Routes each response back to the initiator that issued the request.
- Sits between the FC demux stage and the shared L2/TCDM bus.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the response-routing FIFO; legal range 1..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_req_i  in  2  per-initiator request
- in_add_i  in  2*ADDR_WIDTH  per-initiator address; initiator i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- in_wen_i  in  2  per-initiator write-enable, active-low (1 = read)
- in_wdata_i  in  2*DATA_WIDTH  per-initiator write data
- in_be_i  in  2*DATA_WIDTH/8  per-initiator byte enables
- in_gnt_o  out  2  per-initiator grant
- in_r_valid_o  out  2  per-initiator response valid
- in_r_rdata_o  out  DATA_WIDTH  response data, shared by both initiators; qualify with in_r_valid_o
- out_req_o  out  1  target request
- out_add_o  out  ADDR_WIDTH  target address
- out_wen_o  out  1  target write-enable
- out_wdata_o  out  DATA_WIDTH  target write data
- out_be_o  out  DATA_WIDTH/8  target byte enables
- out_gnt_i  in  1  target grant
- out_r_valid_i  in  1  target response valid
- out_r_rdata_i  in  DATA_WIDTH  target response data
- resp_err_o  out  1  registered one-cycle pulse: target response arrived with no outstanding entry

Behaviour:
- Reset: rr_ptr=0 (initiator 0 has priority), FIFO empty (count=0), resp_err_o=0.
  - All other outputs are combinational: with no requests and no responses they are 0.
- Request phase (combinational):
  - sel = the requesting initiator. If both request, sel = rr_ptr.
  - out_req_o = |in_req_i & ~full.
  - out_add/wen/wdata/be = sel initiator's fields when out_req_o=1, else all 0 (operand isolation).
- Grant:
  - in_gnt_o[sel] = out_gnt_i & out_req_o.
  - The non-selected initiator's gnt = 0.
  - A request is accepted in the cycle req & gnt are both high; the initiator holds req and its fields stable until granted.
- Push on acceptance: sel (1 bit) is pushed into the FIFO.
- Round-robin update:
  - On acceptance, rr_ptr <= ~sel.
  - If there is no acceptance, rr_ptr is unchanged. An initiator waiting on a target stall therefore keeps its priority.
- Full: when count==MAX_OUTSTANDING, out_req_o=0 and both gnt=0.
  - This holds even if a response pops in the same cycle; no bypass.
- Response phase:
  - Target responses are in order, exactly one per accepted request, no earlier than 1 cycle after the grant.
  - On out_r_valid_i with count>0: in_r_valid_o[head]=1, in_r_rdata_o=out_r_rdata_i, head is popped.
  - in_r_rdata_o is passed through unconditionally.
- Simultaneous push and pop: count is unchanged, pointers both advance, wrap modulo MAX_OUTSTANDING.
- Error case: out_r_valid_i with count==0.
  - in_r_valid_o=0, no pop.
  - resp_err_o=1 in the next cycle for exactly one cycle.
- Latency: grant is 0 cycles after request when the target grants. The response is routed combinationally in the same cycle as out_r_valid_i.
- Reset asserted mid-transaction: FIFO cleared and rr_ptr=0.
  - Outstanding responses arriving after reset are flagged via resp_err_o and not forwarded.

Test Plan:
1. Single initiator 0 read, out_gnt_i=1, response 2 cycles later with rdata 0xDEADBEEF -> in_gnt_o=01 in cycle 0; in_r_valid_o=01 with in_r_rdata_o=0xDEADBEEF in cycle 2; in_r_valid_o[1] stays 0.
2. Both initiators request continuously, target always grants, 1-cycle response latency -> grants alternate 01,10,01,10 starting with initiator 0 after reset; responses routed 0,1,0,1.
3. MAX_OUTSTANDING=2, target grants but withholds responses -> exactly 2 grants, then out_req_o=0. A single response then allows one more grant in the following cycle, not the same cycle.
4. Target stalls (out_gnt_i=0) for 3 cycles while initiator 1 holds priority and both request -> rr_ptr stays 1; initiator 1 is granted in the first cycle out_gnt_i=1; initiator 1's address stays on out_add_o throughout.
5. Write from initiator 1 (wen=0, be=0xF, wdata=0x12345678) while initiator 0 idle -> out_* carries exactly those values; initiator-0 fields never appear on out_*.
6. Spurious out_r_valid_i with empty FIFO, then async reset asserted with 1 outstanding -> spurious case: resp_err_o pulses 1 cycle, no in_r_valid_o. Reset case: FIFO empty and the next response after reset also raises resp_err_o.
